// File: rtl/tt_regbank_pkg.sv
// Shared types and field-position helpers for the tt_io_regbank command register bank.
package tt_regbank_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_INC   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_EXEC     = 2'b01,
      S_WAIT_LOW = 2'b10
   } state_e;

   function automatic int stb_pos(input int io_w);
      return io_w - 1;
   endfunction

   function automatic int op_hi_pos(input int io_w);
      return io_w - 2;
   endfunction

   function automatic int op_lo_pos(input int io_w);
      return io_w - 3;
   endfunction

endpackage

// File: rtl/tt_sync2.sv
// Parametrised-width two-flop synchroniser with synchronous active-high reset.
module tt_sync2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/tt_io_regbank.sv
// Tiny Tapeout pin-bundle top with a strobed command register bank.
// Optional macro TT_REGBANK_AUTOINC_EN adds an address pointer and turns OP=00 into STREAM-WRITE.
module tt_io_regbank
   import tt_regbank_pkg::*;
#(
   parameter int IO_W  = 8,
   parameter int NREGS = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic [IO_W-1:0] ui_in,
   input  logic [IO_W-1:0] uio_in,
   output logic [IO_W-1:0] uo_out,
   output logic [IO_W-1:0] uio_out,
   output logic [IO_W-1:0] uio_oe
);

   localparam int ADDR_W = $clog2(NREGS);
   localparam int STB    = stb_pos(IO_W);
   localparam int OP_HI  = op_hi_pos(IO_W);
   localparam int OP_LO  = op_lo_pos(IO_W);
   localparam logic [IO_W-1:0]   ONE_D = 1;
   localparam logic [ADDR_W-1:0] ONE_A = 1;

   logic [IO_W-1:0] ui_s2;
   logic [IO_W-1:0] uio_s2;
   logic            stb_s3_q;
   logic            stb_rise;
   logic            unused_ui;

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [IO_W-1:0] data_q, data_d;
   logic [IO_W-1:0] regs_q [NREGS];
   logic [IO_W-1:0] regs_d [NREGS];
   logic [IO_W-1:0] uo_q, uo_d;
`ifdef TT_REGBANK_AUTOINC_EN
   logic [ADDR_W-1:0] ptr_q, ptr_d;
`endif

   tt_sync2 #(.W(IO_W)) u_sync_ui  (.clk(clk), .rst(rst), .d_i(ui_in),  .q_o(ui_s2));
   tt_sync2 #(.W(IO_W)) u_sync_uio (.clk(clk), .rst(rst), .d_i(uio_in), .q_o(uio_s2));

   assign stb_rise  = ui_s2[STB] & ~stb_s3_q;
   assign unused_ui = ^ui_s2;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      data_d  = data_q;
      regs_d  = regs_q;
      uo_d    = uo_q;
`ifdef TT_REGBANK_AUTOINC_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (stb_rise && ena) begin
               op_d    = op_e'(ui_s2[OP_HI:OP_LO]);
               addr_d  = ui_s2[ADDR_W-1:0];
               data_d  = uio_s2;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_WRITE: regs_d[addr_q] = data_q;
               OP_READ:  uo_d = regs_q[addr_q];
               OP_INC:   regs_d[addr_q] = regs_q[addr_q] + ONE_D;
               OP_NOP: begin
`ifdef TT_REGBANK_AUTOINC_EN
                  regs_d[ptr_q] = data_q;
                  ptr_d         = ptr_q + ONE_A;
`endif
               end
               default: ;
            endcase
`ifdef TT_REGBANK_AUTOINC_EN
            if (op_q != OP_NOP) ptr_d = addr_q + ONE_A;
`endif
            // The command always finishes; ena low only prevents the wait for STB release.
            state_d = ena ? S_WAIT_LOW : S_IDLE;
         end
         S_WAIT_LOW: begin
            if (!ena || !ui_s2[STB]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stb_s3_q <= 1'b0;
         state_q  <= S_IDLE;
         op_q     <= OP_NOP;
         addr_q   <= '0;
         data_q   <= '0;
         regs_q   <= '{default: '0};
         uo_q     <= '0;
`ifdef TT_REGBANK_AUTOINC_EN
         ptr_q    <= '0;
`endif
      end else begin
         stb_s3_q <= ui_s2[STB];
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         regs_q   <= regs_d;
         uo_q     <= uo_d;
`ifdef TT_REGBANK_AUTOINC_EN
         ptr_q    <= ptr_d;
`endif
      end
   end

   assign uo_out  = uo_q;
   assign uio_out = regs_q[1];
   assign uio_oe  = regs_q[0];

endmodule

// File: tb/tb_tt_io_regbank.sv
// Directed self-checking bench for tt_io_regbank (IO_W=8, NREGS=4).
module tb_tt_io_regbank;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks   = 0;
   int failures = 0;

   tt_io_regbank #(.IO_W(8), .NREGS(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%02h expected=0x%02h", tag, got, exp);
      end
   endtask

   // Raise STB with the given command/data for 'hold' clock edges, then drop it and let the FSM settle.
   task automatic cmd(input logic [7:0] ui, input logic [7:0] d, input int hold);
      @(negedge clk);
      ui_in  = ui;
      uio_in = d;
      repeat (hold) @(negedge clk);
      ui_in = ui & 8'h7F;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      rst    = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_uo", uo_out, 8'h00);
      chk("reset_uio_out", uio_out, 8'h00);
      chk("reset_uio_oe", uio_oe, 8'h00);

      // WRITE reg1 with latency probe: not visible after edge 3, visible after edge 4
      @(negedge clk);
      ui_in  = 8'hA1;
      uio_in = 8'hA5;
      repeat (3) @(posedge clk);
      #1 chk("write_edge3", uio_out, 8'h00);
      @(posedge clk);
      #1 chk("write_edge4", uio_out, 8'hA5);
      @(negedge clk);
      ui_in = 8'h21;
      repeat (6) @(negedge clk);

      cmd(8'hC1, 8'h00, 6);
      chk("read_reg1", uo_out, 8'hA5);

      cmd(8'hA0, 8'h0F, 6);
      chk("oe_reg0", uio_oe, 8'h0F);
      chk("oe_uo_hold", uo_out, 8'hA5);

      cmd(8'hA2, 8'hFF, 6);
      cmd(8'hE2, 8'h00, 6);
      cmd(8'hC2, 8'h00, 6);
      chk("inc_wrap", uo_out, 8'h00);

      cmd(8'hE3, 8'h00, 20);
      cmd(8'hC3, 8'h00, 6);
      chk("single_shot", uo_out, 8'h01);

      // ena gating: strobe while disabled is dropped and never replayed
      ena = 1'b0;
      cmd(8'hA1, 8'h3C, 6);
      chk("ena_low_write", uio_out, 8'hA5);
      ena = 1'b1;
      repeat (10) @(negedge clk);
      chk("ena_raise", uio_out, 8'hA5);
      chk("ena_uo_hold", uo_out, 8'h01);

      // STB dropped early: command still executes once
      cmd(8'hE1, 8'h00, 2);
      chk("short_stb_inc", uio_out, 8'hA6);

      // Reset while in EXEC wipes the pending command
      @(negedge clk);
      ui_in  = 8'hA1;
      uio_in = 8'h77;
      repeat (3) @(posedge clk);
      #1;
      rst   = 1'b1;
      ui_in = 8'h21;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("midexec_uo", uo_out, 8'h00);
      chk("midexec_uio_out", uio_out, 8'h00);
      chk("midexec_uio_oe", uio_oe, 8'h00);
      repeat (4) @(negedge clk);
      chk("midexec_no_replay", uio_out, 8'h00);
      cmd(8'hA1, 8'h5A, 6);
      chk("post_reset_write", uio_out, 8'h5A);

`ifdef TT_REGBANK_AUTOINC_EN
      cmd(8'hA1, 8'h11, 6);
      cmd(8'h80, 8'h22, 6);
      cmd(8'h80, 8'h33, 6);
      chk("stream_reg1_kept", uio_out, 8'h11);
      cmd(8'h80, 8'h44, 6);
      chk("stream_wrap_reg0", uio_oe, 8'h44);
      cmd(8'hC2, 8'h00, 6);
      chk("stream_reg2", uo_out, 8'h22);
      cmd(8'hC3, 8'h00, 6);
      chk("stream_reg3", uo_out, 8'h33);
`else
      cmd(8'hC1, 8'h00, 6);
      cmd(8'h80, 8'h99, 6);
      chk("nop_uio_out", uio_out, 8'h5A);
      chk("nop_uio_oe", uio_oe, 8'h00);
      chk("nop_uo", uo_out, 8'h5A);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
